// File: rtl/fwuart_rx.sv
// UART receiver: 16x oversampled, centre-sampled 8N1 deserialiser with a
// valid/ready byte output and framing-error / overrun pulses.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for rxd_s low (start edge)
// START     | counting to mid start bit to reject glitches
// DATA      | sampling DATA_BITS data bits at bit centre, LSB first
// STOP      | sampling the stop bit at its centre
// WAIT_IDLE | stop bit was low; hold off until the line returns high
module fwuart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clock_x16,
    input  logic       rxd,
    output logic [7:0] dat_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic                 rxd_m;
    logic                 rxd_s;
    logic [2:0]           state;
    logic [3:0]           cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [7:0]           byte_ext;
    logic                 stop_hit;
    logic                 done;
    logic                 bad_stop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    assign stop_hit = (state == S_STOP) && clock_x16 && (cnt == 4'd15);
    assign done     = stop_hit && rxd_s;
    assign bad_stop = stop_hit && !rxd_s;

    always_comb begin
        byte_ext = '0;
        byte_ext[DATA_BITS-1:0] = shreg;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            bit_idx <= 3'd0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state <= S_START;
                        cnt   <= 4'd0;
                    end
                end
                S_START: begin
                    if (clock_x16) begin
                        if (cnt == 4'd7) begin
                            if (rxd_s) begin
                                state <= S_IDLE;
                            end else begin
                                state   <= S_DATA;
                                cnt     <= 4'd0;
                                bit_idx <= 3'd0;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (clock_x16) begin
                        if (cnt == 4'd15) begin
                            // Shifting in at the top leaves the first bit in bit 0.
                            shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
                            cnt     <= 4'd0;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'(DATA_BITS - 1)) begin
                                state <= S_STOP;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (clock_x16) begin
                        if (cnt == 4'd15) begin
                            cnt   <= 4'd0;
                            state <= rxd_s ? S_IDLE : S_WAIT_IDLE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxd_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // A completing byte may replace the held one only if it is accepted on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dat_o     <= 8'd0;
            valid_o   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= done && valid_o && !ready_i;
            if (done && (!valid_o || ready_i)) begin
                dat_o   <= byte_ext;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
